mem_bus_responder: RTL and testbench



---
 rtl/mem_bus_responder_if.sv | 20 ++
 rtl/mem_bus_responder.sv | 81 ++++++++
 tb/tb_mem_bus_responder.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_responder_if.sv
// mem_bus_responder_if: request/response bus between the core's memory port and the responder
interface mem_bus_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: wait-stated word RAM responder with byte strobes and a memory-mapped toggle register
module mem_bus_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] TOGGLE_ADDR = 32'h0000_1000
) (
  input  logic               clk,
  input  logic               reset,
  mem_bus_responder_if.slave bus,
  output logic [31:0]        toggle_value
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t      state, state_d;
  logic [3:0]  cnt, cnt_d;
  logic        ready_q, accept, enter_resp, we_q, we_a, in_ram, is_tog, ok, err_q;
  logic [31:0] addr_q, wdata_q, addr_a, wdata_a, rdata_q;
  logic [3:0]  wstrb_q, wstrb_a;
  logic [29:0] widx;
  logic [31:0] mem [DEPTH_WORDS];
  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = state == S_RESP;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  // next state, wait counter, and decode of the request being serviced (live bus fields on the accept edge so zero wait states work)
  always_comb begin
    accept     = bus.req_valid && ready_q;
    state_d    = state == S_IDLE ? (accept ? (WAIT_CYCLES > 0 ? S_WAIT : S_RESP) : S_IDLE)
               : state == S_WAIT ? (cnt == 4'd1 ? S_RESP : S_WAIT) : S_IDLE;
    cnt_d      = accept ? 4'(WAIT_CYCLES) : state == S_WAIT ? cnt - 4'd1 : cnt;
    enter_resp = state_d == S_RESP;
    we_a       = accept ? bus.req_we : we_q;
    addr_a     = accept ? bus.req_addr : addr_q;
    wdata_a    = accept ? bus.req_wdata : wdata_q;
    wstrb_a    = accept ? bus.req_wstrb : wstrb_q;
    widx       = addr_a[31:2];
    is_tog     = addr_a == TOGGLE_ADDR;
    in_ram     = widx < 30'(DEPTH_WORDS);
    ok         = addr_a[1:0] == 2'b00 && (is_tog || in_ram);
  end
  // state register; ready is registered so it stays low through reset and rises the cycle after
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      ready_q <= state_d == S_IDLE;
    end
  end
  // capture the accepted request for the wait states
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= bus.req_we;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      wstrb_q <= bus.req_wstrb;
    end
  end
  // perform the access on entry to RESP: response data/error and toggle register update
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q      <= '0;
      err_q        <= 1'b0;
      toggle_value <= '0;
    end else if (enter_resp) begin
      err_q   <= !ok;
      rdata_q <= ok && !we_a ? (is_tog ? toggle_value : mem[widx[AW-1:0]]) : '0;
      for (int i = 0; i < 4; i++)
        if (ok && we_a && is_tog && wstrb_a[i]) toggle_value[8*i+:8] <= wdata_a[8*i+:8];
    end
  end
  // byte-strobed RAM write, never cleared by reset
  always_ff @(posedge clk) begin
    if (!reset && enter_resp && ok && we_a && in_ram)
      for (int i = 0; i < 4; i++)
        if (wstrb_a[i]) mem[widx[AW-1:0]][8*i+:8] <= wdata_a[8*i+:8];
  end
endmodule

// File: tb/tb_mem_bus_responder.sv
// tb_mem_bus_responder: directed and randomized checks of the memory responder against a byte-addressed model
module tb_mem_bus_responder;
  localparam int          W     = 2;
  localparam int          DEPTH = 256;
  localparam logic [31:0] TOG   = 32'h0000_1000;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] toggle_value, toggle_value0;
  mem_bus_responder_if bus ();
  mem_bus_responder_if bus0 ();
  mem_bus_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W), .TOGGLE_ADDR(TOG)) dut (
    .clk(clk), .reset(reset), .bus(bus), .toggle_value(toggle_value));
  mem_bus_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .TOGGLE_ADDR(TOG)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .toggle_value(toggle_value0));
  always #5 clk = ~clk;
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  mb [int];
  logic [31:0] mtog = '0;
  logic [31:0] rd, erd, tv;
  logic        er, eer;
  int          lat;
  bit          known;
  // one transaction on the main bus, with the expected outcome computed from a byte-addressed model
  task automatic run(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                     output logic [31:0] ard, output logic aer, output logic [31:0] atv, output int alat,
                     output logic [31:0] xrd, output logic xer, output bit xknown);
    int g = 0;
    xer    = (a[1:0] != 2'b00) || !(a == TOG || a < 32'(DEPTH * 4));
    xrd    = '0;
    xknown = 1;
    if (!xer && we) begin
      for (int b = 0; b < 4; b++)
        if (ws[b]) begin
          if (a == TOG) mtog[8*b+:8] = wd[8*b+:8];
          else mb[int'(a) + b] = wd[8*b+:8];
        end
    end else if (!xer) begin
      if (a == TOG) xrd = mtog;
      else
        for (int b = 0; b < 4; b++)
          if (mb.exists(int'(a) + b)) xrd[8*b+:8] = mb[int'(a) + b];
          else xknown = 0;
    end
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.req_wstrb = ws;
    while (!bus.req_ready && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    alat = 1;
    while (!bus.rsp_valid && alat < 40) begin
      @(posedge clk); #1;
      alat++;
    end
    ard = bus.rsp_rdata;
    aer = bus.rsp_err;
    atv = toggle_value;
    @(posedge clk); #1;
  endtask
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b expected 0", bus.req_ready); end
    checks++; if (bus0.req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0_low: got %b expected 0", bus0.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
    checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", bus.rsp_rdata); end
    checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.rsp_err); end
    checks++; if (toggle_value !== 32'h0) begin errors++; $display("FAIL reset_toggle: got %h expected 0", toggle_value); end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b expected 1", bus.req_ready); end
  endtask
  task automatic test_basic();
    run(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, tv, lat, erd, eer, known);
    checks++; if (lat !== W + 1) begin errors++; $display("FAIL basic_wr_latency: got %0d expected %0d", lat, W + 1); end
    checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL basic_wr_rsp: got err=%b rdata=%h expected err=0 rdata=0", er, rd); end
    run(1'b0, 32'h10, 32'h0, 4'h0, rd, er, tv, lat, erd, eer, known);
    checks++; if (lat !== W + 1) begin errors++; $display("FAIL basic_rd_latency: got %0d expected %0d", lat, W + 1); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rd_data: got %h expected deadbeef", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL basic_rd_err: got %b expected 0", er); end
  endtask
  task automatic test_strobe();
    run(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, tv, lat, erd, eer, known);
    run(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, tv, lat, erd, eer, known);
    run(1'b0, 32'h20, 32'h0, 4'h0, rd, er, tv, lat, erd, eer, known);
    checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL strobe_rd: got %h expected 11bb33dd", rd); end
  endtask
  task automatic test_toggle();
    run(1'b1, TOG, 32'h1, 4'hF, rd, er, tv, lat, erd, eer, known);
    checks++; if (tv !== 32'h1) begin errors++; $display("FAIL toggle_at_rsp: got %h expected 1", tv); end
    checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL toggle_wr_rsp: got err=%b rdata=%h expected err=0 rdata=0", er, rd); end
    run(1'b0, TOG, 32'h0, 4'h0, rd, er, tv, lat, erd, eer, known);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL toggle_rd: got %h expected 1", rd); end
  endtask
  task automatic test_errors();
    run(1'b0, 32'h13, 32'h0, 4'h0, rd, er, tv, lat, erd, eer, known);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_misaligned: got err=%b rdata=%h expected err=1 rdata=0", er, rd); end
    run(1'b1, 32'h0, 32'h55AA0FF0, 4'hF, rd, er, tv, lat, erd, eer, known);
    run(1'b1, 32'(DEPTH * 4), 32'h0BADBAD0, 4'hF, rd, er, tv, lat, erd, eer, known);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_range: got err=%b rdata=%h expected err=1 rdata=0", er, rd); end
    run(1'b0, 32'h0, 32'h0, 4'h0, rd, er, tv, lat, erd, eer, known);
    checks++; if (rd !== 32'h55AA0FF0 || er !== 1'b0) begin errors++; $display("FAIL err_word0_intact: got err=%b rdata=%h expected err=0 rdata=55aa0ff0", er, rd); end
  endtask
  task automatic test_back_to_back();
    int r = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h10;
    bus.req_wstrb = 4'h0;
    while (!bus.rsp_valid && r < 20) begin
      @(posedge clk); #1;
      r++;
    end
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_first_rsp: got %b expected 1", bus.rsp_valid); end
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      checks++; if (bus.rsp_valid !== (i % (W + 2) == 0)) begin errors++; $display("FAIL b2b_valid cycle %0d: got %b expected %b", i, bus.rsp_valid, i % (W + 2) == 0); end
      checks++; if (bus.req_ready !== (i % (W + 2) == 1)) begin errors++; $display("FAIL b2b_ready cycle %0d: got %b expected %b", i, bus.req_ready, i % (W + 2) == 1); end
    end
    checks++; if (bus.rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_rdata: got %h expected deadbeef", bus.rsp_rdata); end
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic test_back_to_back_w0();
    int r = 0;
    bus0.req_valid = 1'b1;
    bus0.req_we    = 1'b0;
    bus0.req_addr  = 32'h10;
    bus0.req_wstrb = 4'h0;
    while (!bus0.rsp_valid && r < 20) begin
      @(posedge clk); #1;
      r++;
    end
    checks++; if (bus0.rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b0_first_rsp: got %b expected 1", bus0.rsp_valid); end
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      checks++; if (bus0.rsp_valid !== (i % 2 == 0)) begin errors++; $display("FAIL b2b0_valid cycle %0d: got %b expected %b", i, bus0.rsp_valid, i % 2 == 0); end
      checks++; if (bus0.req_ready !== (i % 2 == 1)) begin errors++; $display("FAIL b2b0_ready cycle %0d: got %b expected %b", i, bus0.req_ready, i % 2 == 1); end
    end
    checks++; if (bus0.rsp_err !== 1'b0) begin errors++; $display("FAIL b2b0_err: got %b expected 0", bus0.rsp_err); end
    bus0.req_valid = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic test_reset_mid();
    run(1'b1, 32'h40, 32'h12345678, 4'hF, rd, er, tv, lat, erd, eer, known);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h40;
    bus.req_wdata = 32'hCAFEF00D;
    bus.req_wstrb = 4'hF;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    reset = 1'b1;
    mtog = '0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_rsp %0d: got %b expected 0", i, bus.rsp_valid); end
      checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready_low %0d: got %b expected 0", i, bus.req_ready); end
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready_after: got %b expected 1", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_rsp_after: got %b expected 0", bus.rsp_valid); end
    checks++; if (toggle_value !== 32'h0) begin errors++; $display("FAIL midrst_toggle: got %h expected 0", toggle_value); end
    run(1'b0, 32'h40, 32'h0, 4'h0, rd, er, tv, lat, erd, eer, known);
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL midrst_prior_value: got %h expected 12345678", rd); end
  endtask
  task automatic test_random();
    logic [31:0] a;
    int k;
    for (int i = 0; i < 16; i++)
      run(1'b1, 32'h100 + 32'(i * 4), $urandom, 4'hF, rd, er, tv, lat, erd, eer, known);
    for (int n = 0; n < 40; n++) begin
      k = int'($urandom_range(0, 9));
      a = k == 0 ? 32'h100 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3))
        : k == 1 ? 32'(DEPTH * 4) + 32'($urandom_range(0, 15)) * 4
        : k == 2 ? TOG : 32'h100 + 32'($urandom_range(0, 15)) * 4;
      run(1'($urandom), a, $urandom, 4'($urandom), rd, er, tv, lat, erd, eer, known);
      checks++; if (lat !== W + 1) begin errors++; $display("FAIL rand_latency %0d addr=%h: got %0d expected %0d", n, a, lat, W + 1); end
      checks++; if (er !== eer) begin errors++; $display("FAIL rand_err %0d addr=%h: got %b expected %b", n, a, er, eer); end
      checks++; if (tv !== mtog) begin errors++; $display("FAIL rand_toggle %0d addr=%h: got %h expected %h", n, a, tv, mtog); end
      if (known) begin
        checks++; if (rd !== erd) begin errors++; $display("FAIL rand_rdata %0d addr=%h: got %h expected %h", n, a, rd, erd); end
      end
    end
  endtask
  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_wstrb = '0;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0; bus0.req_wstrb = '0;
    test_reset();
    test_basic();
    test_strobe();
    test_toggle();
    test_errors();
    test_back_to_back();
    test_back_to_back_w0();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
